// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one floating-point adder between two
// requesters, with a bounded wait for the adder's completion pulse.
module fp_add_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         op0,
  input  logic         op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         err,
  output logic [W-1:0] fpu_a,
  output logic [W-1:0] fpu_b,
  output logic         fpu_op,
  output logic         fpu_start,
  input  logic [W-1:0] fpu_y,
  input  logic         fpu_ready,
  input  logic         fpu_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           winner_q, winner_d;
  logic           last_q, last_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic [W-1:0]   fpu_a_q, fpu_a_d;
  logic [W-1:0]   fpu_b_q, fpu_b_d;
  logic           fpu_op_q, fpu_op_d;
  logic           fpu_start_q, fpu_start_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic           pick;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    fpu_start_d = 1'b0;
    res_d       = res_q;
    err_d       = err_q;

    // A lone requester wins outright; on contention the side not served last wins.
    pick = (req0 && req1) ? ~last_q : req1;

    unique case (state_q)
      IDLE: begin
        if ((req0 || req1) && !fpu_busy) begin
          winner_d    = pick;
          fpu_a_d     = pick ? a1 : a0;
          fpu_b_d     = pick ? b1 : b0;
          fpu_op_d    = pick ? op1 : op0;
          fpu_start_d = 1'b1;
          gnt_d       = pick ? 2'b10 : 2'b01;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fpu_ready) begin
          res_d   = fpu_y;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        last_d  = winner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      winner_q    <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= 1'b0;
      fpu_start_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      fpu_start_q <= fpu_start_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign res       = res_q;
  assign err       = err_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_start = fpu_start_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a stand-in adder model, per-requester scoreboards
// and grant-order / timing checks around the arbitration and timeout paths.
module tb_fp_add_arbiter;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         op0 = 1'b0, op1 = 1'b0;
  logic         gnt0, gnt1, done0, done1, err, fpu_op, fpu_start;
  logic [W-1:0] res, fpu_a, fpu_b;
  logic [W-1:0] fpu_y = '0;
  logic         fpu_ready = 1'b0, fpu_busy = 1'b0;

  fp_add_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .err(err), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_start(fpu_start), .fpu_y(fpu_y), .fpu_ready(fpu_ready), .fpu_busy(fpu_busy)
  );

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic op; } op_t;
  typedef struct packed { logic [W-1:0] res; logic err; } exp_t;

  op_t  pend0[$], pend1[$];
  exp_t exp0[$], exp1[$];
  int   gnt_log[$];

  int checks = 0, failures = 0, cyc = 0;
  int fpu_lat = 3, lat_cd = 0;
  logic [W-1:0] lat_y = '0, stray_y = '0;
  logic stray_ready = 1'b0;
  int start_cyc = 0, done_cyc = 0, last_done_cyc = -100, start_gap = 0, load_cyc = 0;
  int n_start = 0, n_done = 0;
  logic [W-1:0] start_a = '0, start_b = '0, done_fpu_a = '0;
  logic start_op = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in adder: one known IEEE case, otherwise integer add/sub as a tag.
  function automatic logic [W-1:0] fpu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
    return op ? a - b : a + b;
  endfunction

  function automatic op_t mk_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    return o;
  endfunction

  function automatic exp_t mk_exp(input op_t o);
    exp_t e;
    e.res = (fpu_lat > 0) ? fpu_model(o.a, o.b, o.op) : '0;
    e.err = (fpu_lat > 0) ? 1'b0 : 1'b1;
    return e;
  endfunction

  task automatic load0();
    op_t o = pend0.pop_front();
    a0 = o.a; b0 = o.b; op0 = o.op; req0 = 1'b1;
    exp0.push_back(mk_exp(o));
    load_cyc = cyc;
  endtask

  task automatic load1();
    op_t o = pend1.pop_front();
    a1 = o.a; b1 = o.b; op1 = o.op; req1 = 1'b1;
    exp1.push_back(mk_exp(o));
    load_cyc = cyc;
  endtask

  // One cycle: observe outputs at the falling edge, then drive next inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("one_gnt", {63'd0, gnt0 & gnt1}, 64'd0);
    check("one_done", {63'd0, done0 & done1}, 64'd0);
    check("done_without_gnt", {63'd0, (done0 & ~gnt0) | (done1 & ~gnt1)}, 64'd0);

    fpu_ready = 1'b0;
    if (fpu_start) begin
      n_start++;
      start_cyc = cyc;
      start_gap = cyc - last_done_cyc;
      start_a = fpu_a; start_b = fpu_b; start_op = fpu_op;
      gnt_log.push_back(gnt1 ? 1 : 0);
      lat_cd = fpu_lat;
      lat_y  = fpu_model(fpu_a, fpu_b, fpu_op);
    end else if (lat_cd > 0) begin
      lat_cd--;
      if (lat_cd == 0) begin
        fpu_ready = 1'b1;
        fpu_y     = lat_y;
      end
    end
    if (stray_ready) begin
      fpu_ready   = 1'b1;
      fpu_y       = stray_y;
      stray_ready = 1'b0;
    end

    if (done0) begin
      n_done++; done_cyc = cyc; last_done_cyc = cyc; done_fpu_a = fpu_a;
      if (exp0.size() == 0) check("done0_unexpected", {63'd0, done0}, 64'd0);
      else begin
        e = exp0.pop_front();
        check("res0", res, e.res);
        check("err0", err, e.err);
      end
      if (pend0.size() > 0) load0(); else req0 = 1'b0;
    end else if (!req0 && pend0.size() > 0 && rst_n) load0();

    if (done1) begin
      n_done++; done_cyc = cyc; last_done_cyc = cyc; done_fpu_a = fpu_a;
      if (exp1.size() == 0) check("done1_unexpected", {63'd0, done1}, 64'd0);
      else begin
        e = exp1.pop_front();
        check("res1", res, e.res);
        check("err1", err, e.err);
      end
      if (pend1.size() > 0) load1(); else req1 = 1'b0;
    end else if (!req1 && pend1.size() > 0 && rst_n) load1();
  endtask

  task automatic drain(input string tag, input int max);
    int i = 0;
    while ((pend0.size() + pend1.size() + exp0.size() + exp1.size()) > 0 && i < max) begin
      tick();
      i++;
    end
    check({tag, "_drain"}, 64'(pend0.size() + pend1.size() + exp0.size() + exp1.size()), 64'd0);
    tick();
  endtask

  task automatic wait_start(input string tag, input int max);
    int s = n_start;
    for (int i = 0; i < max && n_start == s; i++) tick();
    check({tag, "_started"}, 64'(n_start), 64'(s + 1));
  endtask

  task automatic check_order(input string tag, input int n, input logic [7:0] pattern);
    check({tag, "_order_len"}, 64'(gnt_log.size()), 64'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      check($sformatf("%s_order%0d", tag, i), 64'(gnt_log[i]), {63'd0, pattern[i]});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, {62'd0, gnt1, gnt0}, 64'd0);
    check({tag, "_done"}, {62'd0, done1, done0}, 64'd0);
    check({tag, "_start_op_err"}, {61'd0, fpu_start, fpu_op, err}, 64'd0);
    check({tag, "_res"}, res, 64'd0);
    check({tag, "_fpu_ab"}, {fpu_a, fpu_b}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    lat_cd = 0;
    tick(); tick();
  endtask

  initial begin
    int c0, s, b;

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request: latency and operand latching while in flight
    fpu_lat = 3;
    gnt_log.delete();
    pend0.push_back(mk_op(32'h3F80_0000, 32'h4000_0000, 1'b0));
    tick();
    c0 = load_cyc;
    wait_start("single", 10);
    check("single_start_lat", 64'(start_cyc - c0), 64'd1);
    check("single_latched", {start_a, start_b}, {32'h3F80_0000, 32'h4000_0000});
    check("single_latched_op", {63'd0, start_op}, 64'd0);
    a0 = 32'hFFFF_FFFF; b0 = 32'h1234_5678; op0 = 1'b1;
    drain("single", 20);
    check("single_done_lat", 64'(done_cyc - c0), 64'd5);
    check("single_hold_a", done_fpu_a, 64'h3F80_0000);
    check_order("single", 1, 8'b0);

    // Simultaneous requests after reset: 0 first, then 1 after one IDLE cycle
    do_reset();
    rst_n = 1'b1;
    gnt_log.delete();
    pend0.push_back(mk_op(32'd1, 32'd2, 1'b0));
    pend1.push_back(mk_op(32'd10, 32'd3, 1'b1));
    drain("simul", 50);
    check_order("simul", 2, 8'b0000_0010);
    check("simul_gap", 64'(start_gap), 64'd2);

    // Fairness with both held: 0,1,0,1 (reloads right at done)
    gnt_log.delete();
    pend0.push_back(mk_op(32'd100, 32'd5, 1'b0));
    pend0.push_back(mk_op(32'd200, 32'd7, 1'b1));
    pend1.push_back(mk_op(32'd300, 32'd9, 1'b0));
    pend1.push_back(mk_op(32'd400, 32'd11, 1'b1));
    drain("fair", 100);
    check_order("fair", 4, 8'b0000_1010);

    // Lone requester wins without priority
    gnt_log.delete();
    pend1.push_back(mk_op(32'h55, 32'h22, 1'b1));
    drain("lone", 30);
    check_order("lone", 1, 8'b0000_0001);

    // Timeout, then stray ready in IDLE, then normal operation
    fpu_lat = 0;
    pend0.push_back(mk_op(32'hABC, 32'h1, 1'b0));
    drain("tmo", 200);
    check("tmo_lat", 64'(done_cyc - start_cyc), 64'(TIMEOUT + 1));
    stray_y = 32'hDEAD_BEEF; stray_ready = 1'b1;
    s = n_done;
    repeat (4) tick();
    check("tmo_stray_nodone", 64'(n_done), 64'(s));
    check("tmo_hold_res_err", {res, 31'd0, err}, 64'd1);
    fpu_lat = 2;
    pend1.push_back(mk_op(32'h777, 32'h111, 1'b0));
    drain("after_tmo", 30);

    // Busy hold-off
    fpu_busy = 1'b1;
    s = n_start;
    pend1.push_back(mk_op(32'h9000, 32'h0009, 1'b1));
    repeat (6) tick();
    check("busy_no_start", 64'(n_start), 64'(s));
    fpu_busy = 1'b0;
    b = cyc;
    tick();
    check("busy_start_cyc", 64'(start_cyc), 64'(b + 1));
    drain("busy", 30);

    // Reset in WAIT after requester 0 was served last, then stray ready
    pend0.push_back(mk_op(32'h42, 32'h24, 1'b0));
    drain("pre_rst", 30);
    fpu_lat = 0;
    pend1.push_back(mk_op(32'h1111, 32'h2222, 1'b0));
    wait_start("wait_rst", 10);
    repeat (3) tick();
    do_reset();
    check_zero("mid_rst");
    rst_n = 1'b1;
    tick();
    stray_y = 32'hCAFE_F00D; stray_ready = 1'b1;
    s = n_done;
    repeat (5) tick();
    check("rst_stray_nodone", 64'(n_done), 64'(s));
    check_zero("after_rst");
    fpu_lat = 2;
    gnt_log.delete();
    pend0.push_back(mk_op(32'h10, 32'h20, 1'b0));
    pend1.push_back(mk_op(32'h30, 32'h40, 1'b1));
    drain("post_rst", 50);
    check_order("post_rst", 2, 8'b0000_0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
